// File: rtl/incline_led_disp.sv
// Incline-to-LED display engine: raw, block-averaged, peak-hold and bar-graph views of a signed
// incline stream. The averager and peak tracker always run so that switching views shows current data.
module incline_led_disp #(
    parameter int IN_W      = 13,
    parameter int LED_W     = 8,
    parameter int SLICE_LSB = 1,
    parameter int AVG_LOG2  = 2,
    parameter int HOLD_CYC  = 50_000_000,
    parameter int BAR_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] incline,
    input  logic                   vld,
    input  logic [1:0]             mode,
    output logic [LED_W-1:0]       LED,
    output logic                   avg_vld
);

    localparam int MAG_W = IN_W - 1;
    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W = $clog2(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_AVG  = 2'd1,
        MODE_PEAK = 2'd2,
        MODE_BAR  = 2'd3
    } disp_mode_e;

    logic [MAG_W-1:0]        mag;
    logic [MAG_W-1:0]        lvl;
    logic signed [IN_W-1:0]  neg;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_sh;
    logic [CNT_W-1:0]        cnt;
    logic signed [IN_W-1:0]  avg;
    logic [MAG_W-1:0]        peak;
    logic [IN_W-1:0]         peak_ext;
    logic [TMR_W-1:0]        hold_tmr;
    disp_mode_e              mode_q;
    logic [LED_W-1:0]        bar;
    logic [LED_W-1:0]        led_nxt;
    logic                    unused_ok;

    // The most-negative sample has no positive twin in IN_W bits, so it saturates.
    assign neg = -incline;
    always_comb begin
        mag = incline[MAG_W-1:0];
        if (incline[IN_W-1]) begin
            if (incline == {1'b1, {(IN_W-1){1'b0}}})
                mag = '1;
            else
                mag = neg[MAG_W-1:0];
        end
    end

    assign sum      = acc + ACC_W'(incline);
    assign sum_sh   = sum >>> AVG_LOG2;
    assign peak_ext = IN_W'(peak);
    assign lvl      = mag >> BAR_SHIFT;
    assign unused_ok = ^{sum_sh, avg, peak_ext};

    // Segment i lights when the level exceeds i, i.e. (1<<min(lvl,LED_W))-1.
    for (genvar i = 0; i < LED_W; i++) begin : g_bar
        assign bar[i] = (lvl > MAG_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            avg     <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (vld) begin
                if (cnt == CNT_LAST) begin
                    avg     <= sum_sh[IN_W-1:0];
                    acc     <= '0;
                    cnt     <= '0;
                    avg_vld <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Strictly larger magnitudes refresh the hold; equal ones do not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak     <= '0;
            hold_tmr <= '0;
        end else if (vld && ((mag > peak) || (hold_tmr == '0))) begin
            peak     <= mag;
            hold_tmr <= TMR_LOAD;
        end else if (hold_tmr != '0) begin
            hold_tmr <= hold_tmr - TMR_W'(1);
        end
    end

    always_comb begin
        led_nxt = LED;
        if (mode != mode_q) begin
            led_nxt = '0;
        end else begin
            case (mode_q)
                MODE_RAW:  if (vld)     led_nxt = incline[SLICE_LSB +: LED_W];
                MODE_AVG:  if (avg_vld) led_nxt = avg[SLICE_LSB +: LED_W];
                MODE_PEAK:              led_nxt = peak_ext[SLICE_LSB +: LED_W];
                MODE_BAR:  if (vld)     led_nxt = bar;
                default:                led_nxt = LED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            LED    <= '0;
            mode_q <= MODE_RAW;
        end else begin
            LED    <= led_nxt;
            mode_q <= disp_mode_e'(mode);
        end
    end

endmodule

// File: tb/tb_incline_led_disp.sv
// Bench for incline_led_disp: directed vector table, peak-hold sequences, then random traffic
// compared cycle by cycle against a sample-level reference model.
module tb_incline_led_disp;

    localparam int IN_W  = 13;
    localparam int LED_W = 8;
    localparam int HOLD  = 16;
    localparam int BLK   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic signed [IN_W-1:0] incline;
    logic                   vld;
    logic [1:0]             mode;
    logic [LED_W-1:0]       LED;
    logic                   avg_vld;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int m_led, m_avg_vld, m_avg, m_peak, m_hold, m_mode_q;
    int blk[$];

    typedef struct {
        bit r;
        bit v;
        int x;
        int md;
        int led;
        bit av;
    } vec_t;
    vec_t tbl[$];

    incline_led_disp #(
        .IN_W(IN_W), .LED_W(LED_W), .SLICE_LSB(1), .AVG_LOG2(2),
        .HOLD_CYC(HOLD), .BAR_SHIFT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .incline(incline), .vld(vld),
        .mode(mode), .LED(LED), .avg_vld(avg_vld)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 4095) a = 4095;
        return a;
    endfunction

    function automatic int slice(input int x);
        logic [IN_W-1:0] b;
        b = IN_W'(x);
        return int'(b[8:1]);
    endfunction

    function automatic int bar(input int m);
        int n;
        n = m / 256;
        if (n > LED_W) n = LED_W;
        return (1 << n) - 1;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit v, input int x, input int md, input int led, input bit av);
        vec_t e;
        e.r = r; e.v = v; e.x = x; e.md = md; e.led = led; e.av = av;
        tbl.push_back(e);
    endtask

    // Drive one cycle, advance the model, compare after the edge.
    task automatic step(input bit r, input bit v, input int x, input int md);
        int mg, nl, sum, q;
        bit nav;
        rst_n   = ~r;
        vld     = v;
        incline = IN_W'(x);
        mode    = 2'(md);
        if (r) begin
            m_led = 0; m_avg_vld = 0; m_avg = 0; m_peak = 0; m_hold = 0; m_mode_q = 0;
            blk.delete();
        end else begin
            mg = mag_of(x);
            if (md != m_mode_q) nl = 0;
            else begin
                case (md)
                    0:       nl = v ? slice(x) : m_led;
                    1:       nl = m_avg_vld ? slice(m_avg) : m_led;
                    2:       nl = slice(m_peak);
                    default: nl = v ? bar(mg) : m_led;
                endcase
            end
            nav = 1'b0;
            if (v) begin
                blk.push_back(x);
                if (blk.size() == BLK) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    q = sum / BLK;
                    if (sum < 0 && (sum % BLK) != 0) q = q - 1;
                    m_avg = q;
                    nav = 1'b1;
                    blk.delete();
                end
            end
            if (v && (mg > m_peak || m_hold == 0)) begin
                m_peak = mg;
                m_hold = HOLD - 1;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            m_led = nl; m_avg_vld = nav; m_mode_q = md;
        end
        @(posedge clk);
        #1;
        check("model LED", int'(LED), m_led);
        check("model avg_vld", int'(avg_vld), m_avg_vld);
    endtask

    initial begin
        int x, md;
        bit r, v;
        rst_n = 1'b0; vld = 1'b0; incline = '0; mode = 2'd0;

        // RAW
        add(1, 0, 0, 0, 'h00, 0);
        add(0, 1, 'h1FE, 0, 'hFF, 0);
        add(0, 1, -256, 0, 'h80, 0);
        add(0, 0, 0, 0, 'h80, 0);
        // AVG
        add(1, 0, 0, 1, 'h00, 0);
        add(0, 0, 0, 1, 'h00, 0);
        add(0, 1, 10, 1, 'h00, 0);
        add(0, 1, 20, 1, 'h00, 0);
        add(0, 1, 30, 1, 'h00, 0);
        add(0, 1, -4, 1, 'h00, 1);
        add(0, 0, 0, 1, 'h07, 0);
        add(0, 1, -1, 1, 'h07, 0);
        add(0, 1, -1, 1, 'h07, 0);
        add(0, 1, -1, 1, 'h07, 0);
        add(0, 1, -2, 1, 'h07, 1);
        add(0, 0, 0, 1, 'hFF, 0);
        // BAR
        add(1, 0, 0, 3, 'h00, 0);
        add(0, 0, 0, 3, 'h00, 0);
        add(0, 1, -1024, 3, 'h0F, 0);
        add(0, 1, -4096, 3, 'hFF, 0);
        add(0, 1, 255, 3, 'h00, 0);
        // RAW -> BAR switch on a vld cycle; the sample still counts toward the block
        add(1, 0, 0, 0, 'h00, 0);
        add(0, 1, 170, 0, 'h55, 0);
        add(0, 1, 512, 3, 'h00, 0);
        add(0, 1, 512, 3, 'h03, 0);
        add(0, 1, 6, 3, 'h00, 1);
        add(0, 0, 0, 3, 'h00, 0);
        // reset mid-block discards the partial sum
        add(1, 0, 0, 1, 'h00, 0);
        add(0, 0, 0, 1, 'h00, 0);
        add(0, 1, 100, 1, 'h00, 0);
        add(0, 1, 200, 1, 'h00, 0);
        add(1, 0, 0, 1, 'h00, 0);
        add(0, 0, 0, 1, 'h00, 0);
        add(0, 1, 4, 1, 'h00, 0);
        add(0, 1, 8, 1, 'h00, 0);
        add(0, 1, 12, 1, 'h00, 0);
        add(0, 1, 16, 1, 'h00, 1);
        add(0, 0, 0, 1, 'h05, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].x, tbl[i].md);
            check($sformatf("vec%0d LED", i), int'(LED), tbl[i].led);
            check($sformatf("vec%0d avg_vld", i), int'(avg_vld), int'(tbl[i].av));
        end

        // PEAK hold, expiry and equal-magnitude behaviour
        step(1, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 1, 100, 2);
        step(0, 1, -300, 2);
        check("peak after 100", int'(LED), 'h32);
        step(0, 1, 50, 2);
        check("peak 300 held", int'(LED), 'h96);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 2);
        check("peak 300 after idle", int'(LED), 'h96);
        step(0, 1, 50, 2);
        step(0, 0, 0, 2);
        check("peak reload 50", int'(LED), 'h19);
        step(0, 1, -50, 2);
        for (int i = 0; i < 13; i++) step(0, 0, 0, 2);
        step(0, 1, 40, 2);
        step(0, 0, 0, 2);
        check("equal mag no reload", int'(LED), 'h14);

        // Random traffic against the model
        step(1, 0, 0, 0);
        md = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 8191)) - 4096;
            else x = int'($urandom_range(0, 600)) - 300;
            if ($urandom_range(0, 29) == 0) md = int'($urandom_range(0, 3));
            step(r, v, x, md);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
